// File: rtl/ahb_output_port_bank.sv
// AHB-Lite bank of output channel registers with byte lanes,
// SET/CLR/TGL aliases and programmable data-phase wait states.
module ahb_output_port_bank #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic [31:0]                     HADDR,
  input  logic [31:0]                     HWDATA,
  input  logic [2:0]                      HSIZE,
  input  logic [1:0]                      HTRANS,
  input  logic                            HWRITE,
  input  logic                            HREADY,
  input  logic                            HSEL,
  output logic [31:0]                     HRDATA,
  output logic                            HREADYOUT,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] oPort
);

  localparam logic [1:0] R_DATA = 2'd0;
  localparam logic [1:0] R_SET  = 2'd1;
  localparam logic [1:0] R_CLR  = 2'd2;
  localparam logic [2:0] WS     = 3'(WAIT_STATES);

  typedef logic [DATA_WIDTH-1:0] word_t;

  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [3:0] ch_q, ch_d;
  logic [1:0] reg_q, reg_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] cnt_q, cnt_d;

  word_t port_q [NUM_PORTS];
  word_t port_d [NUM_PORTS];

  logic        capture;
  logic        commit;
  logic [3:0]  lane_mask;
  logic [31:0] full_m;
  word_t       bmask;
  word_t       wdat;
  logic [31:0] rd_word;

  assign capture = HREADY & HSEL & HTRANS[1];

  always_comb begin
    lane_mask = 4'b1111;
    unique case (1'b1)
      (HSIZE == 3'd0): lane_mask = 4'b0001 << HADDR[1:0];
      (HSIZE == 3'd1): lane_mask = 4'b0011 << {HADDR[1], 1'b0};
      default:         lane_mask = 4'b1111;
    endcase
  end

  // Flags only move when the bus advances; they hold across our wait states.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ch_d   = ch_q;
    reg_d  = reg_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
    if (HREADY) begin
      wr_d = capture & HWRITE;
      rd_d = capture & ~HWRITE;
      if (capture) begin
        ch_d   = HADDR[7:4];
        reg_d  = HADDR[3:2];
        mask_d = lane_mask;
        cnt_d  = WS;
      end
    end
  end

  assign full_m = {{8{mask_q[3]}}, {8{mask_q[2]}},
                   {8{mask_q[1]}}, {8{mask_q[0]}}};
  assign bmask  = full_m[DATA_WIDTH-1:0];
  assign wdat   = HWDATA[DATA_WIDTH-1:0] & bmask;
  assign commit = wr_q & HREADY & (cnt_q == 3'd0);

  always_comb begin
    for (int c = 0; c < NUM_PORTS; c++) begin
      port_d[c] = port_q[c];
      if (commit && ch_q == 4'(c)) begin
        unique case (1'b1)
          (reg_q == R_DATA): port_d[c] = (port_q[c] & ~bmask) | wdat;
          (reg_q == R_SET):  port_d[c] = port_q[c] | wdat;
          (reg_q == R_CLR):  port_d[c] = port_q[c] & ~wdat;
          default:           port_d[c] = port_q[c] ^ wdat;
        endcase
      end
    end
  end

  // Channels beyond NUM_PORTS never match, so they read as zero.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_PORTS; c++) begin
      if (ch_q == 4'(c)) begin
        rd_word[DATA_WIDTH-1:0] = port_q[c];
      end
    end
  end

  assign HRDATA    = rd_q ? rd_word : 32'd0;
  assign HREADYOUT = (cnt_q == 3'd0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      ch_q   <= '0;
      reg_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      for (int c = 0; c < NUM_PORTS; c++) begin
        port_q[c] <= RESET_VALUE[DATA_WIDTH-1:0];
      end
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ch_q   <= ch_d;
      reg_q  <= reg_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      for (int c = 0; c < NUM_PORTS; c++) begin
        port_q[c] <= port_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign oPort[g*DATA_WIDTH +: DATA_WIDTH] = port_q[g];
  end

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:8], HTRANS[0], HWDATA, full_m};

endmodule
